fifo_tx_serial_ctrl: RTL and testbench
======================================

// Module: fifo_tx_serial_ctrl
// PURPOSE
// - Pops bytes from the TX FIFO and serializes each one LSB-first onto bitstream.
// - Emits one bitstream_en strobe per bit at a programmable bit rate.
// - Sits between the TX FIFO read port and the bitstream sink (PHY or the sim decoder).
// - Groups bytes into bursts of at most BURST_MAX, separated by an idle gap.
// PARAMETERS
// - DIV        default 4   clocks per bit period; legal range >=2
// - BURST_MAX  default 16  max back-to-back bytes before a forced gap; legal range >=1
// - GAP_CYCLES default 2   idle clocks inserted after a burst; legal range >=1
// PORTS
// - clk         in   1   single clock; all logic on its rising edge
// - rst         in   1   synchronous, active-high reset
// - enable      in   1   allows new bytes to start; sampled in IDLE and at byte end
// - fifo_empty  in   1   TX FIFO empty flag
// - fifo_rd_en  out  1   one-cycle FIFO pop; fifo_data is valid the cycle after
// - fifo_data   in   8   FIFO read data, read latency 1
// - bitstream   out  1   serial data, LSB first
// - bitstream_en out 1   one-cycle strobe at mid-bit; bitstream is stable around it
// - byte_done   out  1   one-cycle pulse after the last bit period of a byte
// - busy        out  1   high whenever state != IDLE
// - tx_count    out  16  bytes completed since reset; wraps 0xFFFF->0x0000
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; internal counters 0.
// - Reset mid-byte aborts immediately: no further strobes; the partial byte is not counted.
// - States: IDLE, FETCH, LOAD, SHIFT, [PARITY], GAP.
// - IDLE: if enable && !fifo_empty, go to FETCH on the next clk; burst_cnt=0.
// - FETCH (1 cycle): fifo_rd_en=1 (Moore output); go to LOAD.
// - LOAD (1 cycle): shreg<=fifo_data; bit_cnt=0; div_cnt=0; go to SHIFT.
//   - fifo_empty is ignored here, since the pop is already committed.
// - SHIFT: each bit lasts DIV cycles; div_cnt runs 0..DIV-1.
//   - bitstream <= shreg[bit_cnt], driven when div_cnt==0.
//   - bitstream_en=1 only in the cycle where div_cnt==DIV/2 (integer divide).
//   - At div_cnt==DIV-1: bit_cnt++; after bit 7, leave to PARITY or the end-of-byte step.
// - End of byte, in the cycle after the last bit period:
//   - byte_done=1 for one cycle; tx_count++; burst_cnt++.
//   - If enable && !fifo_empty && burst_cnt<BURST_MAX: go to FETCH.
//   - Otherwise go to GAP.
// - GAP: hold for GAP_CYCLES with no strobes, then go to IDLE.
// - bitstream holds its last value in FETCH, LOAD, GAP and IDLE; it clears only on reset.
// - Latency: fifo_empty falls in IDLE at cycle 0 -> fifo_rd_en at cycle 1 -> first strobe at cycle 3+DIV/2.
// - Inter-byte: a FETCH+LOAD overhead of 2 strobe-free cycles separates bytes within a burst.
// - enable low mid-byte: the current byte completes, then GAP then IDLE; no new pop.
// - FIFO goes empty mid-burst: the current byte completes, then GAP; no pop is ever issued on empty.
// - Width rules: div_cnt is $clog2(DIV) bits; bit_cnt is 4 bits; burst_cnt is $clog2(BURST_MAX+1) bits.
// CONFIGURATION
// - Macro: FIFO_TX_SERIAL_PARITY_EN
// - Defined: after bit 7 the block enters PARITY for one extra bit period.
//   - bitstream = ^byte (even parity); one extra bitstream_en strobe; 9 strobes per byte.
//   - byte_done fires after the parity bit.
// - Undefined: PARITY state absent; exactly 8 strobes per byte.
// TESTING
// - Common setup: DIV=4; decoder on bitstream/bitstream_en; FIFO model with read latency 1.
// - Single byte: push 0xA5, enable=1.
//   - bitstream per bit = 1,0,1,0,0,1,0,1; 8 strobes spaced 4 clk apart.
//   - One byte_done; decoder outputs 0xA5; tx_count=1.
// - Burst limit: BURST_MAX=2, push 0x01,0x02,0x03.
//   - Bytes 1-2 separated by 2 strobe-free cycles.
//   - GAP_CYCLES plus IDLE re-entry before byte 3; tx_count=3.
// - Enable drop: deassert enable at strobe 3 of 0x3C with 0x55 queued.
//   - 0x3C completes; no fifo_rd_en for 0x55; busy falls after GAP.
// - Reset mid-byte: rst at strobe 4 of 0xFF.
//   - All outputs 0 the next cycle; tx_count=0; no byte_done.
// - Empty FIFO: enable=1, fifo_empty=1 for 50 cycles -> fifo_rd_en, busy and bitstream_en stay 0.
// - Parity (macro defined): byte 0x07 -> 9 strobes; 9th bit=1; byte 0x03 -> 9th bit=0.

Source files
------------

// File: rtl/fifo_tx_serial_ctrl_if.sv
// Handshake bundle between the TX FIFO read port, the serializer and the bitstream sink.
// master: the serializer side; slave: the FIFO/sink side.
interface fifo_tx_serial_ctrl_if;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data;
    logic        bitstream;
    logic        bitstream_en;
    logic        byte_done;
    logic        busy;
    logic [15:0] tx_count;

    modport master (
        input  enable, fifo_empty, fifo_data,
        output fifo_rd_en, bitstream, bitstream_en, byte_done, busy, tx_count
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  fifo_rd_en, bitstream, bitstream_en, byte_done, busy, tx_count
    );
endinterface

// File: rtl/fifo_tx_serial_ctrl.sv
// Pops bytes from the TX FIFO and shifts them out LSB-first, one mid-bit strobe per bit, in bursts.
// Define FIFO_TX_SERIAL_PARITY_EN to append an even-parity bit after each byte.
module fifo_tx_serial_ctrl #(
    parameter int DIV        = 4,
    parameter int BURST_MAX  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_tx_serial_ctrl_if.master bus
);
    localparam int DW = $clog2(DIV);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DW-1:0] DIV_HALF  = DW'(DIV / 2);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] SHIFT  = 3'd3;
    localparam logic [2:0] GAP    = 3'd4;
`ifdef FIFO_TX_SERIAL_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    logic [2:0]    state;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_inc;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    shreg;
    logic          bitstream_r;
    logic          byte_done_r;
    logic [15:0]   tx_count_r;
    logic          byte_end;
    logic          fetch_next;

`ifdef FIFO_TX_SERIAL_PARITY_EN
    assign byte_end = (state == PARITY) && (div_cnt == DIV_LAST);
`else
    assign byte_end = (state == SHIFT) && (div_cnt == DIV_LAST) && (bit_cnt == 4'd7);
`endif

    // The burst limit is judged on the count including the byte just finished.
    assign burst_inc  = burst_cnt + BW'(1);
    assign fetch_next = bus.enable && !bus.fifo_empty && (burst_inc < BURST_LIM);

    // Byte register: data path only, captured in LOAD when the FIFO read data is valid.
    always_ff @(posedge clk) begin
        if (state == LOAD) shreg <= bus.fifo_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            burst_cnt   <= '0;
            gap_cnt     <= '0;
            bitstream_r <= 1'b0;
            byte_done_r <= 1'b0;
            tx_count_r  <= '0;
        end else begin
            byte_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (bus.enable && !bus.fifo_empty) state <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == '0) bitstream_r <= shreg[bit_cnt[2:0]];
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
`ifdef FIFO_TX_SERIAL_PARITY_EN
                        if (bit_cnt == 4'd7) state <= PARITY;
`endif
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
`ifdef FIFO_TX_SERIAL_PARITY_EN
                PARITY: begin
                    if (div_cnt == '0) bitstream_r <= even_parity(shreg);
                    if (div_cnt == DIV_LAST) div_cnt <= '0;
                    else                     div_cnt <= div_cnt + DW'(1);
                end
`endif
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // End-of-byte bookkeeping overrides the per-state next state.
            if (byte_end) begin
                byte_done_r <= 1'b1;
                tx_count_r  <= tx_count_r + 16'd1;
                burst_cnt   <= burst_inc;
                gap_cnt     <= '0;
                state       <= fetch_next ? FETCH : GAP;
            end
        end
    end

    assign bus.fifo_rd_en = (state == FETCH);
    assign bus.busy       = (state != IDLE);
    assign bus.bitstream  = bitstream_r;
    assign bus.byte_done  = byte_done_r;
    assign bus.tx_count   = tx_count_r;
`ifdef FIFO_TX_SERIAL_PARITY_EN
    assign bus.bitstream_en = ((state == SHIFT) || (state == PARITY)) && (div_cnt == DIV_HALF);
`else
    assign bus.bitstream_en = (state == SHIFT) && (div_cnt == DIV_HALF);
`endif
endmodule

// File: tb/tb_fifo_tx_serial_ctrl.sv
// Bench for fifo_tx_serial_ctrl: FIFO model with read latency 1, strobe-driven decoder,
// table of single-byte vectors, hand-written corner sequences and a randomized run.
module tb_fifo_tx_serial_ctrl;
    localparam int DIV        = 4;
    localparam int BURST_MAX  = 2;
    localparam int GAP_CYCLES = 2;
`ifdef FIFO_TX_SERIAL_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_tx_serial_ctrl_if bus();

    fifo_tx_serial_ctrl #(
        .DIV(DIV), .BURST_MAX(BURST_MAX), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_byte;
        logic       exp_par;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] fq[$];
    logic [7:0] dec[$];
    logic [7:0] sent[$];
    int bstart[$];
    int blast[$];
    int nb, strobes, done_cnt, rd_cnt, busy_cyc, last_strobe, first_strobe, first_rd;
    int run, max_run, odd_gap;
    logic last_par;
    logic [NBITS-1:0] cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        nb = 0; strobes = 0; done_cnt = 0; rd_cnt = 0; busy_cyc = 0;
        last_strobe = -1000; first_strobe = -1; first_rd = -1;
        run = 0; max_run = 0; odd_gap = 0; last_par = 1'b0; cur = '0;
        dec.delete(); bstart.delete(); blast.delete();
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: FIFO model update, then observe the DUT just after the edge.
    task automatic step();
        logic pop;
        int gap;
        pop = bus.fifo_rd_en;
        if (pop) check("pop_nonempty", fq.size() != 0, 1);
        @(posedge clk);
        #1;
        cyc++;
        if (pop && fq.size() != 0) bus.fifo_data = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.busy) busy_cyc++;
        if (bus.byte_done) done_cnt++;
        if (bus.bitstream_en) begin
            if (first_strobe < 0) first_strobe = cyc;
            if (nb > 0) begin
                check("bit_spacing", cyc - last_strobe, DIV);
            end else begin
                bstart.push_back(cyc);
                if (dec.size() > 0) begin
                    gap = cyc - last_strobe;
                    if (gap == DIV + 2) run++;
                    else begin
                        run = 1;
                        if (gap < DIV + GAP_CYCLES + 3) odd_gap++;
                    end
                end else begin
                    run = 1;
                end
                if (run > max_run) max_run = run;
            end
            cur[nb] = bus.bitstream;
            nb++;
            strobes++;
            last_strobe = cyc;
            if (nb == NBITS) begin
                dec.push_back(cur[7:0]);
                blast.push_back(cyc);
`ifdef FIFO_TX_SERIAL_PARITY_EN
                last_par = cur[8];
                check("parity_bit", cur[8], ^cur[7:0]);
`endif
                nb = 0;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (dec.size() < n && k < budget) begin
            step();
            k++;
        end
        if (dec.size() < n) check("timeout_bytes", dec.size(), n);
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            step();
            k++;
        end
        if (bus.busy) check("timeout_idle", bus.busy, 0);
    endtask

    vec_t vecs[7];
    logic [15:0] txc0;
    logic [7:0]  got;
    int t0, td, tb_fall, k, pushed;

    initial begin
        bus.enable     = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        vecs[0] = '{8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{8'h07, 8'h07, 1'b1};
        vecs[2] = '{8'h03, 8'h03, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b1};
        vecs[6] = '{8'h3C, 8'h3C, 1'b0};

        clear_mon();
        rst = 1'b1;
        run_cycles(3);
        check("rst_busy", bus.busy, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_bitstream", bus.bitstream, 0);
        check("rst_bit_en", bus.bitstream_en, 0);
        check("rst_byte_done", bus.byte_done, 0);
        check("rst_tx_count", bus.tx_count, 0);
        rst = 1'b0;

        // Enabled but empty FIFO: nothing may happen.
        clear_mon();
        bus.enable = 1'b1;
        run_cycles(50);
        check("empty_rd_en", rd_cnt, 0);
        check("empty_busy", busy_cyc, 0);
        check("empty_strobes", strobes, 0);

        // Single-byte vectors from idle.
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            txc0 = bus.tx_count;
            t0   = cyc;
            bus.enable = 1'b1;
            push(vecs[i].din);
            run_until_bytes(1, 200);
            run_until_idle(50);
            got = (dec.size() > 0) ? dec[0] : 8'h00;
            check("vec_byte", got, vecs[i].exp_byte);
            check("vec_strobes", strobes, NBITS);
            check("vec_done", done_cnt, 1);
            check("vec_rd_cnt", rd_cnt, 1);
            check("vec_tx_count", bus.tx_count, txc0 + 16'd1);
            check("vec_rd_latency", first_rd - t0, 1);
            check("vec_strobe_latency", first_strobe - t0, 3 + DIV / 2);
`ifdef FIFO_TX_SERIAL_PARITY_EN
            check("vec_parity", last_par, vecs[i].exp_par);
`endif
        end

        // Burst limit: two bytes back-to-back, forced gap plus idle before the third.
        clear_mon();
        txc0 = bus.tx_count;
        push(8'h01); push(8'h02); push(8'h03);
        run_until_bytes(3, 400);
        run_until_idle(50);
        check("burst_b0", dec.size() > 0 ? dec[0] : 8'hEE, 8'h01);
        check("burst_b1", dec.size() > 1 ? dec[1] : 8'hEE, 8'h02);
        check("burst_b2", dec.size() > 2 ? dec[2] : 8'hEE, 8'h03);
        if (bstart.size() >= 3 && blast.size() >= 2) begin
            check("burst_gap12", bstart[1] - blast[0], DIV + 2);
            check("burst_gap23", bstart[2] - blast[1], DIV + GAP_CYCLES + 3);
        end else begin
            check("burst_bytes_seen", bstart.size(), 3);
        end
        check("burst_tx_count", bus.tx_count, txc0 + 16'd3);
        check("burst_rd_cnt", rd_cnt, 3);

        // Enable drop at strobe 3 of 0x3C with 0x55 queued.
        clear_mon();
        txc0 = bus.tx_count;
        push(8'h3C); push(8'h55);
        k = 0;
        while (strobes < 3 && k < 100) begin step(); k++; end
        check("drop_reach_strobe3", strobes, 3);
        bus.enable = 1'b0;
        k = 0;
        while (done_cnt < 1 && k < 100) begin step(); k++; end
        td = cyc;
        k = 0;
        while (bus.busy && k < 50) begin step(); k++; end
        tb_fall = cyc;
        check("drop_busy_fall", tb_fall - td, GAP_CYCLES);
        run_cycles(20);
        check("drop_byte", dec.size() > 0 ? dec[0] : 8'hEE, 8'h3C);
        check("drop_done", done_cnt, 1);
        check("drop_rd_cnt", rd_cnt, 1);
        check("drop_fifo_left", fq.size(), 1);
        check("drop_tx_count", bus.tx_count, txc0 + 16'd1);
        bus.enable = 1'b1;
        run_until_bytes(2, 200);
        run_until_idle(50);
        check("drop_drain", dec.size() > 1 ? dec[1] : 8'hEE, 8'h55);

        // Reset at strobe 4 of 0xFF.
        clear_mon();
        push(8'hFF);
        k = 0;
        while (strobes < 4 && k < 100) begin step(); k++; end
        check("rst_mid_strobe4", strobes, 4);
        rst = 1'b1;
        step();
        check("rstm_busy", bus.busy, 0);
        check("rstm_bitstream", bus.bitstream, 0);
        check("rstm_bit_en", bus.bitstream_en, 0);
        check("rstm_byte_done", bus.byte_done, 0);
        check("rstm_rd_en", bus.fifo_rd_en, 0);
        check("rstm_tx_count", bus.tx_count, 0);
        rst = 1'b0;
        clear_mon();
        run_cycles(30);
        check("rstm_no_done", done_cnt, 0);
        check("rstm_no_strobes", strobes, 0);
        check("rstm_tx_count_hold", bus.tx_count, 0);

        // Randomized traffic against the stream-level model.
        clear_mon();
        sent.delete();
        txc0 = bus.tx_count;
        pushed = 0;
        k = 0;
        while (dec.size() < 40 && k < 8000) begin
            if (pushed < 40 && $urandom_range(0, 1) == 0) begin
                got = 8'($urandom);
                push(got);
                sent.push_back(got);
                pushed++;
            end
            bus.enable = (pushed >= 40) ? 1'b1 : ($urandom_range(0, 7) != 0);
            step();
            k++;
        end
        if (dec.size() < 40) check("rand_timeout", dec.size(), 40);
        run_until_idle(50);
        for (int i = 0; i < 40; i++) begin
            if (i < dec.size()) check("rand_byte", dec[i], sent[i]);
        end
        check("rand_done", done_cnt, 40);
        check("rand_rd_cnt", rd_cnt, 40);
        check("rand_tx_count", bus.tx_count, txc0 + 16'd40);
        check("rand_burst_ok", max_run <= BURST_MAX, 1);
        check("rand_gap_ok", odd_gap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
